bram_capture: RTL and testbench

Parametrised ADC-to-BRAM capture engine for one or two 14-bit channels with sample-count control, decimation, an optional trigger arm and selectable packing modes. It drives the write port of the block-RAM store (byte address, 32-bit data, per-byte write enables) in the ADC clock domain. Software reads the buffer through the AXI BRAM controller once `done` is high.

---
 rtl/bram_capture.sv | 170 +++++++++++++++++
 tb/tb_bram_capture.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/bram_capture.sv
// ADC-to-BRAM capture engine: decimates, packs and writes 1 or 2 ADC channels into a
// 32-bit block-RAM write port, with an optional trigger arm stage.
module bram_capture #(
  parameter int unsigned ADC_W      = 14,
  parameter int unsigned DEPTH_LOG2 = 13,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  trig_en,
  input  logic                  trig,
  input  logic [1:0]            mode,
  input  logic [DEPTH_LOG2:0]   num_samples,
  input  logic [15:0]           decim,
  input  logic [ADC_W-1:0]      data_a,
  input  logic [ADC_W-1:0]      data_b,
  input  logic                  data_valid,
  output logic [31:0]           bram_addr,
  output logic [31:0]           bram_wdata,
  output logic [3:0]            bram_we,
  output logic                  busy,
  output logic                  armed,
  output logic                  done,
  output logic [DEPTH_LOG2:0]   count
);

  localparam logic [DEPTH_LOG2:0] FullCount = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {StIdle, StArmed, StCapture, StDone} state_e;

  state_e                  state_q, state_d;
  logic                    trig_q;
  logic [1:0]              mode_q;
  logic [DEPTH_LOG2:0]     n_q;
  logic [15:0]             decim_q;
  logic [15:0]             dcnt_q;
  logic [DEPTH_LOG2:0]     acc_q;
  logic [DEPTH_LOG2:0]     count_q;
  logic                    pend_q;
  logic [31:0]             pend_data_q;
  logic [DEPTH_LOG2-1:0]   pend_idx_q;
  logic [31:0]             addr_q;
  logic [31:0]             wdata_q;
  logic                    we_q;

  logic                    trig_rise;
  logic                    start_ok;
  logic                    take;
  logic                    write;
  logic                    last_write;
  logic [DEPTH_LOG2:0]     n_clamped;
  logic signed [15:0]      a16, b16;
  logic [15:0]             a_al;
  logic [8:0]              legacy_mid;
  logic [31:0]             packed_word;

  assign trig_rise  = trig & ~trig_q;
  assign start_ok   = start & ~abort & ((state_q == StIdle) | (state_q == StDone));
  // Samples are accepted one edge before they are written, so stop accepting once
  // N words are in flight or written, not once N are written.
  assign take       = (state_q == StCapture) & data_valid & ~abort & (dcnt_q == 16'd0) &
                      (acc_q < n_q);
  assign write      = pend_q & ~abort;
  assign last_write = write & ((count_q + 1'b1) == n_q);
  assign n_clamped  = ((num_samples == '0) || (num_samples > FullCount)) ? FullCount :
                      num_samples;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle, StDone: if (start) state_d = trig_en ? StArmed : StCapture;
        StArmed:        if (trig_rise) state_d = StCapture;
        StCapture:      if (last_write) state_d = StDone;
        default:        state_d = StIdle;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    busy  = 1'b0;
    armed = 1'b0;
    done  = 1'b0;
    case (state_q)
      StArmed:   begin busy = 1'b1; armed = 1'b1; end
      StCapture: busy = 1'b1;
      StDone:    done = 1'b1;
      default:   ;
    endcase
  end

  // Sample packing; the legacy format takes the 9 bits below the sign, MSB-aligned.
  always_comb begin
    a16        = 16'($signed(data_a));
    b16        = 16'($signed(data_b));
    a_al       = 16'(data_a) << (16 - ADC_W);
    legacy_mid = 9'(a_al >> 6);
    case (mode_q)
      2'd0:    packed_word = 32'(a16);
      2'd1:    packed_word = {{23{a16[15]}}, ~legacy_mid};
      2'd2:    packed_word = {b16, a16};
      default: packed_word = 32'(b16);
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      trig_q      <= 1'b0;
      mode_q      <= 2'd0;
      n_q         <= '0;
      decim_q     <= 16'd0;
      dcnt_q      <= 16'd0;
      acc_q       <= '0;
      count_q     <= '0;
      pend_q      <= 1'b0;
      pend_data_q <= 32'd0;
      pend_idx_q  <= '0;
      addr_q      <= BASE_ADDR;
      wdata_q     <= 32'd0;
      we_q        <= 1'b0;
    end else begin
      trig_q <= trig;
      we_q   <= write;
      if (write) begin
        addr_q  <= BASE_ADDR + 32'({pend_idx_q, 2'b00});
        wdata_q <= pend_data_q;
        count_q <= count_q + 1'b1;
      end
      pend_q <= take;
      if (take) begin
        pend_data_q <= packed_word;
        pend_idx_q  <= acc_q[DEPTH_LOG2-1:0];
        acc_q       <= acc_q + 1'b1;
      end
      if ((state_q == StCapture) && data_valid && !abort) begin
        dcnt_q <= (dcnt_q == 16'd0) ? decim_q : dcnt_q - 16'd1;
      end
      if (start_ok) begin
        mode_q  <= mode;
        n_q     <= n_clamped;
        decim_q <= decim;
        dcnt_q  <= 16'd0;
        acc_q   <= '0;
        count_q <= '0;
        pend_q  <= 1'b0;
      end
    end
  end

  assign bram_addr  = addr_q;
  assign bram_wdata = wdata_q;
  assign bram_we    = {4{we_q}};
  assign count      = count_q;

endmodule

// File: tb/tb_bram_capture.sv
// Scoreboard bench for bram_capture: a reference model queues the expected writes as
// samples are driven and a negedge monitor pops and compares every bram_we beat.
module tb_bram_capture;

  localparam int unsigned ADC_W = 14;
  localparam int unsigned DL    = 4;
  localparam logic [31:0] BASE  = 32'h4000_0100;

  logic          clk, rstn, start, abort, trig_en, trig, data_valid;
  logic [1:0]    mode;
  logic [DL:0]   num_samples;
  logic [15:0]   decim;
  logic [13:0]   data_a, data_b;
  logic [31:0]   bram_addr, bram_wdata;
  logic [3:0]    bram_we;
  logic          busy, armed, done;
  logic [DL:0]   count;

  bram_capture #(.ADC_W(ADC_W), .DEPTH_LOG2(DL), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .trig_en(trig_en), .trig(trig),
    .mode(mode), .num_samples(num_samples), .decim(decim), .data_a(data_a),
    .data_b(data_b), .data_valid(data_valid), .bram_addr(bram_addr),
    .bram_wdata(bram_wdata), .bram_we(bram_we), .busy(busy), .armed(armed), .done(done),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        last;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // reference model state
  bit          m_cap;
  int          m_dc, m_wr, m_n, m_decim;
  logic [1:0]  m_mode;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] pack(input logic [1:0] md, input logic [13:0] a,
                                       input logic [13:0] b);
    case (md)
      2'd0:    return {{18{a[13]}}, a};
      2'd1:    return {{23{a[13]}}, ~a[12:4]};
      2'd2:    return {{2{b[13]}}, b, {2{a[13]}}, a};
      default: return {{18{b[13]}}, b};
    endcase
  endfunction

  exp_t mon_e;
  always @(negedge clk) begin
    if (bram_we !== 4'h0) begin
      if (sb.size() == 0) begin
        check("spurious_we", 32'(bram_we), 32'h0);
      end else begin
        mon_e = sb.pop_front();
        check("we_bits", 32'(bram_we), 32'hf);
        check("addr", bram_addr, mon_e.addr);
        check("wdata", bram_wdata, mon_e.data);
        check("done_with_we", 32'(done), 32'(mon_e.last));
        check("count_with_we", 32'(count), mon_e.cnt);
      end
    end
  end

  task automatic begin_cap(input logic [1:0] md, input int ns, input int dec, input bit ten);
    start = 1'b1; mode = md; num_samples = (DL+1)'(ns); decim = 16'(dec); trig_en = ten;
    m_n     = (ns == 0 || ns > (1 << DL)) ? (1 << DL) : ns;
    m_dc    = 0;
    m_wr    = 0;
    m_decim = dec;
    m_mode  = md;
    m_cap   = !ten;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input logic [13:0] a, input logic [13:0] b, input bit vld);
    exp_t e;
    data_a = a; data_b = b; data_valid = vld;
    if (m_cap && vld) begin
      if (m_dc == 0) begin
        if (m_wr < m_n) begin
          e.addr = BASE + 32'(4 * m_wr);
          e.data = pack(m_mode, a, b);
          e.last = (m_wr + 1 == m_n);
          e.cnt  = 32'(m_wr + 1);
          sb.push_back(e);
          m_wr++;
        end
        m_dc = m_decim;
      end else begin
        m_dc--;
      end
    end
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100; i++) begin
      if (done) break;
      @(negedge clk);
    end
    check("done_reached", 32'(done), 32'h1);
    @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; start = 1'b0; abort = 1'b0; trig_en = 1'b0; trig = 1'b0;
    mode = 2'd0; num_samples = '0; decim = 16'd0; data_a = '0; data_b = '0;
    data_valid = 1'b0; m_cap = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    check("rst_addr", bram_addr, BASE);
    check("rst_wdata", bram_wdata, 32'h0);
    check("rst_we", 32'(bram_we), 32'h0);
    check("rst_busy", 32'({busy, armed, done}), 32'h0);
    check("rst_count", 32'(count), 32'h0);

    // mode 0 basic: -3, 5, 8191, -8192
    begin_cap(2'd0, 4, 0, 1'b0);
    check("cap_busy", 32'({busy, armed}), 32'h2);
    feed(14'h3FFD, 14'h0, 1'b1);
    feed(14'h0005, 14'h0, 1'b1);
    feed(14'h1FFF, 14'h0, 1'b1);
    feed(14'h2000, 14'h0, 1'b1);
    wait_done();
    check("m0_count", 32'(count), 32'h4);
    check("m0_idle_busy", 32'(busy), 32'h0);

    // mode 1 legacy, mode 2 dual, mode 3 channel B with gaps
    begin_cap(2'd1, 1, 0, 1'b0);
    feed(14'h2010, 14'h0, 1'b1);
    wait_done();
    begin_cap(2'd2, 2, 0, 1'b0);
    feed(14'h3FFF, 14'h0002, 1'b1);
    feed(14'($urandom), 14'($urandom), 1'b1);
    wait_done();
    begin_cap(2'd3, 3, 0, 1'b0);
    for (int i = 0; i < 8; i++) feed(14'($urandom), 14'($urandom), i[0]);
    wait_done();

    // decimation: continuous and with random valid gaps
    begin_cap(2'd0, 3, 2, 1'b0);
    for (int i = 0; i < 12; i++) feed(14'(100 + i), 14'h0, 1'b1);
    wait_done();
    check("decim_count", 32'(count), 32'h3);
    begin_cap(2'd2, 4, 1, 1'b0);
    for (int i = 0; i < 40; i++) feed(14'($urandom), 14'($urandom), 1'($urandom));
    wait_done();

    // trigger arm with trig already high at start
    trig = 1'b1;
    @(negedge clk);
    begin_cap(2'd0, 2, 0, 1'b1);
    check("armed_after_start", 32'({busy, armed}), 32'h3);
    for (int i = 0; i < 5; i++) feed(14'($urandom), 14'h0, 1'b1);
    check("still_armed", 32'(armed), 32'h1);
    trig = 1'b0;
    feed(14'($urandom), 14'h0, 1'b1);
    trig = 1'b1;
    check("armed_at_edge", 32'(armed), 32'h1);
    feed(14'($urandom), 14'h0, 1'b1);
    check("capture_after_edge", 32'({busy, armed}), 32'h2);
    m_cap = 1'b1;
    feed(14'h0123, 14'h0, 1'b1);
    feed(14'h3210, 14'h0, 1'b1);
    wait_done();
    trig = 1'b0;

    // num_samples = 0 means full depth; mid-capture start is ignored
    begin_cap(2'd0, 0, 0, 1'b0);
    for (int i = 0; i < 22; i++) begin
      if (i == 6) begin start = 1'b1; mode = 2'd3; trig_en = 1'b1; end
      feed(14'($urandom), 14'($urandom), 1'b1);
      start = 1'b0; trig_en = 1'b0;
    end
    wait_done();
    check("full_count", 32'(count), 32'(1 << DL));

    // abort mid-capture (with a simultaneous start) cancels the pending write
    begin_cap(2'd0, 10, 0, 1'b0);
    for (int i = 0; i < 3; i++) feed(14'(i + 7), 14'h0, 1'b1);
    abort = 1'b1; start = 1'b1;
    void'(sb.pop_back());
    m_cap = 1'b0;
    feed(14'h0AAA, 14'h0, 1'b1);
    abort = 1'b0; start = 1'b0;
    for (int i = 0; i < 4; i++) feed(14'h0BBB, 14'h0, 1'b1);
    check("abort_state", 32'({busy, armed, done}), 32'h0);
    check("abort_count", 32'(count), 32'h2);
    check("abort_sb", 32'(sb.size()), 32'h0);

    // reset mid-capture
    begin_cap(2'd0, 10, 0, 1'b0);
    for (int i = 0; i < 3; i++) feed(14'(i + 20), 14'h0, 1'b1);
    rstn = 1'b0;
    void'(sb.pop_back());
    m_cap = 1'b0;
    feed(14'h0CCC, 14'h0, 1'b1);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) feed(14'h0DDD, 14'h0, 1'b1);
    check("rst2_state", 32'({busy, armed, done}), 32'h0);
    check("rst2_count", 32'(count), 32'h0);
    check("rst2_addr", bram_addr, BASE);
    check("rst2_wdata", bram_wdata, 32'h0);
    check("rst2_sb", 32'(sb.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
